// File: rtl/gb_alu_pkg.sv
// Shared definitions for the 8-bit ALU and the 16-bit sequencer that drives it.
package gb_alu_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned WORD_W = 16;
   localparam int unsigned FLAG_W = 4;
   localparam int unsigned OP_W   = 5;

   localparam logic [OP_W-1:0] ALU_ADD    = 5'b00000;
   localparam logic [OP_W-1:0] ALU_ADC    = 5'b00001;
   localparam logic [OP_W-1:0] ALU_SUB    = 5'b00010;
   localparam logic [OP_W-1:0] ALU_SBC    = 5'b00011;
   localparam logic [OP_W-1:0] ALU_COPY_A = 5'b11000;

   localparam int unsigned FLAG_C = 0;
   localparam int unsigned FLAG_H = 1;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_Z = 3;

   typedef enum logic [1:0] {
      OP_ADD16    = 2'd0,
      OP_INC16    = 2'd1,
      OP_DEC16    = 2'd2,
      OP_ADD_SP_E = 2'd3
   } op16_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } seq_state_t;

   function automatic logic [OP_W-1:0] lo_alu_op(input op16_t op);
      return (op == OP_DEC16) ? ALU_SUB : ALU_ADD;
   endfunction

   function automatic logic [OP_W-1:0] hi_alu_op(input op16_t op);
      return (op == OP_DEC16) ? ALU_SBC : ALU_ADC;
   endfunction

   function automatic logic [DATA_W-1:0] lo_alu_b(input op16_t op, input logic [WORD_W-1:0] b);
      if (op == OP_INC16 || op == OP_DEC16) return 8'h01;
      return b[7:0];
   endfunction

   // High byte: rr high byte, sign extension of e, or zero with carry/borrow only.
   function automatic logic [DATA_W-1:0] hi_alu_b(input op16_t op, input logic [WORD_W-1:0] b);
      if (op == OP_ADD16)    return b[15:8];
      if (op == OP_ADD_SP_E) return {8{b[7]}};
      return 8'h00;
   endfunction

endpackage

// File: rtl/alu16_sequencer.sv
// Runs a 16-bit ADD/INC/DEC/ADD SP,e as two chained 8-bit ALU passes (low then high byte).
module alu16_sequencer
   import gb_alu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op16,
   input  logic [WORD_W-1:0] a16,
   input  logic [WORD_W-1:0] b16,
   input  logic [FLAG_W-1:0] flag_in,
   output logic              busy,
   output logic              done,
   output logic [WORD_W-1:0] result,
   output logic [FLAG_W-1:0] flag_out,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   output logic [FLAG_W-1:0] alu_flag_in,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [FLAG_W-1:0] alu_flag_out
);

   seq_state_t        r_state;
   op16_t             r_op;
   logic [WORD_W-1:0] r_a;
   logic [WORD_W-1:0] r_b;
   logic [FLAG_W-1:0] r_flags;
   logic [DATA_W-1:0] r_res_lo;
   logic [1:0]        r_lo_hc;
   logic              r_busy;
   logic              r_done;
   logic [WORD_W-1:0] r_result;
   logic [FLAG_W-1:0] r_flag_out;
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [OP_W-1:0]   r_alu_op;
   logic [FLAG_W-1:0] r_alu_flag_in;

   seq_state_t        w_state_nxt;
   logic [DATA_W-1:0] w_alu_a_nxt;
   logic [DATA_W-1:0] w_alu_b_nxt;
   logic [OP_W-1:0]   w_alu_op_nxt;
   logic [FLAG_W-1:0] w_alu_flag_nxt;
   logic [FLAG_W-1:0] w_flag_fin;
   logic              w_accept;

   assign w_accept = (r_state == IDLE) && start;

   // Next state plus the ALU drive for the following cycle, so the drive is registered.
   always_comb begin
      w_state_nxt    = r_state;
      w_alu_a_nxt    = '0;
      w_alu_b_nxt    = '0;
      w_alu_op_nxt   = ALU_COPY_A;
      w_alu_flag_nxt = '0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt    = LO;
               w_alu_a_nxt    = a16[7:0];
               w_alu_b_nxt    = lo_alu_b(op16_t'(op16), b16);
               w_alu_op_nxt   = lo_alu_op(op16_t'(op16));
               w_alu_flag_nxt = flag_in;
            end
         end
         LO: begin
            w_state_nxt    = HI;
            w_alu_a_nxt    = r_a[15:8];
            w_alu_b_nxt    = hi_alu_b(r_op, r_b);
            w_alu_op_nxt   = hi_alu_op(r_op);
            w_alu_flag_nxt = alu_flag_out;
         end
         HI:      w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Final CHNZ as seen at the end of the HI pass.
   always_comb begin
      w_flag_fin = r_flags;
      case (r_op)
         OP_ADD16: begin
            w_flag_fin[FLAG_N] = 1'b0;
            w_flag_fin[FLAG_H] = alu_flag_out[FLAG_H];
            w_flag_fin[FLAG_C] = alu_flag_out[FLAG_C];
         end
         OP_ADD_SP_E: begin
            w_flag_fin         = '0;
            w_flag_fin[FLAG_H] = r_lo_hc[1];
            w_flag_fin[FLAG_C] = r_lo_hc[0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_op          <= OP_ADD16;
         r_a           <= '0;
         r_b           <= '0;
         r_flags       <= '0;
         r_res_lo      <= '0;
         r_lo_hc       <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_result      <= '0;
         r_flag_out    <= '0;
         r_alu_a       <= '0;
         r_alu_b       <= '0;
         r_alu_op      <= ALU_COPY_A;
         r_alu_flag_in <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_busy        <= (w_state_nxt != IDLE);
         r_done        <= (w_state_nxt == DONE);
         r_alu_a       <= w_alu_a_nxt;
         r_alu_b       <= w_alu_b_nxt;
         r_alu_op      <= w_alu_op_nxt;
         r_alu_flag_in <= w_alu_flag_nxt;
         if (w_accept) begin
            r_op    <= op16_t'(op16);
            r_a     <= a16;
            r_b     <= b16;
            r_flags <= flag_in;
         end
         if (r_state == LO) begin
            r_res_lo <= alu_out;
            r_lo_hc  <= {alu_flag_out[FLAG_H], alu_flag_out[FLAG_C]};
         end
         if (r_state == HI) begin
            r_result   <= {alu_out, r_res_lo};
            r_flag_out <= w_flag_fin;
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign result      = r_result;
   assign flag_out    = r_flag_out;
   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign alu_op      = r_alu_op;
   assign alu_flag_in = r_alu_flag_in;

endmodule

// File: tb/tb_alu16_sequencer.sv
// Bench for alu16_sequencer paired with a behavioural 8-bit ALU and a 16-bit arithmetic model.
module tb_alu16_sequencer;
   import gb_alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op16;
   logic [15:0] a16, b16;
   logic [3:0]  flag_in;
   logic        busy, done;
   logic [15:0] result;
   logic [3:0]  flag_out;
   logic [7:0]  alu_a, alu_b, alu_out;
   logic [4:0]  alu_op;
   logic [3:0]  alu_flag_in, alu_flag_out;

   int checks = 0;
   int failures = 0;
   int m_full, m_half, m_cin;

   always #5 clk = ~clk;

   alu16_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .op16(op16), .a16(a16), .b16(b16),
      .flag_in(flag_in), .busy(busy), .done(done), .result(result), .flag_out(flag_out),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_flag_in(alu_flag_in),
      .alu_out(alu_out), .alu_flag_out(alu_flag_out)
   );

   // 8-bit ALU: integer add/subtract with carry/borrow, flags {Z,N,H,C}.
   always_comb begin
      m_cin = 0;
      m_full = 0;
      m_half = 0;
      alu_out = alu_a;
      alu_flag_out = alu_flag_in;
      if (alu_op == ALU_ADC || alu_op == ALU_SBC) m_cin = int'(alu_flag_in[0]);
      if (alu_op == ALU_ADD || alu_op == ALU_ADC) begin
         m_full = int'(alu_a) + int'(alu_b) + m_cin;
         m_half = int'(alu_a[3:0]) + int'(alu_b[3:0]) + m_cin;
         alu_out = 8'(m_full);
         alu_flag_out = {alu_out == 8'h00, 1'b0, m_half > 15, m_full > 255};
      end else if (alu_op == ALU_SUB || alu_op == ALU_SBC) begin
         m_full = int'(alu_a) - int'(alu_b) - m_cin;
         m_half = int'(alu_a[3:0]) - int'(alu_b[3:0]) - m_cin;
         alu_out = 8'(m_full);
         alu_flag_out = {alu_out == 8'h00, 1'b1, m_half < 0, m_full < 0};
      end
   end

   // 16-bit reference: plain arithmetic on the whole word.
   function automatic void ref16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] f, output logic [15:0] r, output logic [3:0] fo);
      int ai = int'(a);
      int bi = int'(b);
      int ei = int'($signed(b[7:0]));
      case (op)
         2'd0: begin
            r  = 16'(ai + bi);
            fo = {f[3], 1'b0, ((ai & 'hFFF) + (bi & 'hFFF)) > 'hFFF, (ai + bi) > 'hFFFF};
         end
         2'd1: begin r = 16'(ai + 1); fo = f; end
         2'd2: begin r = 16'(ai - 1); fo = f; end
         default: begin
            r  = 16'(ai + ei);
            fo = {2'b00, ((ai & 15) + (bi & 15)) > 15, ((ai & 255) + (bi & 255)) > 255};
         end
      endcase
   endfunction

   // Issue one operation from idle and collect what the DUT produces.
   task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] f, output int lat, output logic [15:0] res,
                        output logic [3:0] fl, output logic [4:0] lo_op_s,
                        output logic [7:0] lo_b_s, output logic [7:0] hi_b_s);
      start = 1'b1; op16 = op; a16 = a; b16 = b; flag_in = f;
      @(posedge clk); #1;
      start = 1'b0; op16 = 2'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
      flag_in = 4'($urandom);
      lat = 1; lo_op_s = alu_op; lo_b_s = alu_b;
      @(posedge clk); #1;
      lat = 2; hi_b_s = alu_b;
      while (done !== 1'b1 && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      res = result; fl = flag_out;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (result !== 16'h0000) begin failures++; $display("FAIL reset_result got=%h exp=0000", result); end
      checks++; if (flag_out !== 4'h0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", flag_out); end
      checks++; if (alu_op !== 5'b11000 || alu_a !== 8'h00 || alu_b !== 8'h00 || alu_flag_in !== 4'h0) begin
         failures++; $display("FAIL reset_alu_drive got op=%b a=%h b=%h f=%b exp op=11000 a=00 b=00 f=0000",
                              alu_op, alu_a, alu_b, alu_flag_in);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_add16();
      int lat; logic [15:0] r; logic [3:0] f; logic [4:0] lo; logic [7:0] lb, hb;
      do_op(2'd0, 16'h0FFF, 16'h0001, 4'b1000, lat, r, f, lo, lb, hb);
      checks++; if (lat != 3) begin failures++; $display("FAIL add16_latency got=%0d exp=3", lat); end
      checks++; if (r !== 16'h1000) begin failures++; $display("FAIL add16_h_result got=%h exp=1000", r); end
      checks++; if (f !== 4'b1010) begin failures++; $display("FAIL add16_h_flags got=%b exp=1010", f); end
      do_op(2'd0, 16'hFFFF, 16'h0001, 4'b0000, lat, r, f, lo, lb, hb);
      checks++; if (r !== 16'h0000) begin failures++; $display("FAIL add16_wrap_result got=%h exp=0000", r); end
      checks++; if (f !== 4'b0011) begin failures++; $display("FAIL add16_wrap_flags got=%b exp=0011", f); end
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL add16_idle_after got done=%b busy=%b exp 0 0", done, busy);
      end
   endtask

   task automatic test_inc_dec();
      int lat; logic [15:0] r; logic [3:0] f; logic [4:0] lo; logic [7:0] lb, hb;
      do_op(2'd1, 16'h00FF, 16'hABCD, 4'b0101, lat, r, f, lo, lb, hb);
      checks++; if (r !== 16'h0100) begin failures++; $display("FAIL inc16_result got=%h exp=0100", r); end
      checks++; if (f !== 4'b0101) begin failures++; $display("FAIL inc16_flags got=%b exp=0101", f); end
      do_op(2'd2, 16'h0000, 16'h1234, 4'b1100, lat, r, f, lo, lb, hb);
      checks++; if (r !== 16'hFFFF) begin failures++; $display("FAIL dec16_result got=%h exp=ffff", r); end
      checks++; if (f !== 4'b1100) begin failures++; $display("FAIL dec16_flags got=%b exp=1100", f); end
      checks++; if (lo !== ALU_SUB || lb !== 8'h01) begin
         failures++; $display("FAIL dec16_lo_drive got op=%b b=%h exp op=00010 b=01", lo, lb);
      end
   endtask

   task automatic test_add_sp_e();
      int lat; logic [15:0] r; logic [3:0] f; logic [4:0] lo; logic [7:0] lb, hb;
      do_op(2'd3, 16'hFFF8, 16'h5508, 4'b1111, lat, r, f, lo, lb, hb);
      checks++; if (r !== 16'h0000) begin failures++; $display("FAIL spe_pos_result got=%h exp=0000", r); end
      checks++; if (f !== 4'b0011) begin failures++; $display("FAIL spe_pos_flags got=%b exp=0011", f); end
      do_op(2'd3, 16'h0005, 16'h00FE, 4'b0000, lat, r, f, lo, lb, hb);
      checks++; if (r !== 16'h0003) begin failures++; $display("FAIL spe_neg_result got=%h exp=0003", r); end
      checks++; if (f !== 4'b0011) begin failures++; $display("FAIL spe_neg_flags got=%b exp=0011", f); end
      checks++; if (hb !== 8'hFF) begin failures++; $display("FAIL spe_neg_hi_b got=%h exp=ff", hb); end
   endtask

   task automatic test_random();
      int lat; logic [15:0] r, er; logic [3:0] f, ef; logic [4:0] lo; logic [7:0] lb, hb;
      logic [1:0] op; logic [15:0] a, b; logic [3:0] fi;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = (i % 5 == 0) ? 16'hFFFF : 16'($urandom);
         b  = 16'($urandom);
         fi = 4'($urandom);
         ref16(op, a, b, fi, er, ef);
         do_op(op, a, b, fi, lat, r, f, lo, lb, hb);
         checks++; if (lat != 3) begin failures++; $display("FAIL rand_latency[%0d] got=%0d exp=3", i, lat); end
         checks++; if (r !== er) begin
            failures++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, r, er);
         end
         checks++; if (f !== ef) begin
            failures++; $display("FAIL rand_flags[%0d] op=%0d a=%h b=%h got=%b exp=%b", i, op, a, b, f, ef);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] ops[8]; logic [15:0] as[8], bs[8]; logic [3:0] fs[8];
      logic [15:0] got_r[2]; logic [3:0] got_f[2]; int got_c[2];
      logic [15:0] er; logic [3:0] ef; int pulses = 0;
      for (int j = 0; j < 2; j++) begin got_r[j] = 'x; got_f[j] = 'x; got_c[j] = -1; end
      for (int k = 0; k < 14; k++) begin
         if (k < 8) begin
            ops[k] = 2'($urandom_range(0, 3)); as[k] = 16'($urandom); bs[k] = 16'($urandom);
            fs[k] = 4'($urandom);
            start = 1'b1; op16 = ops[k]; a16 = as[k]; b16 = bs[k]; flag_in = fs[k];
         end else start = 1'b0;
         @(posedge clk); #1;
         if (done === 1'b1) begin
            if (pulses < 2) begin got_r[pulses] = result; got_f[pulses] = flag_out; got_c[pulses] = k; end
            pulses++;
         end
      end
      checks++; if (pulses != 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
      for (int j = 0; j < 2; j++) begin
         ref16(ops[j*4], as[j*4], bs[j*4], fs[j*4], er, ef);
         checks++; if (got_c[j] != j*4 + 2) begin
            failures++; $display("FAIL b2b_timing[%0d] got=%0d exp=%0d", j, got_c[j], j*4 + 2);
         end
         checks++; if (got_r[j] !== er || got_f[j] !== ef) begin
            failures++; $display("FAIL b2b_value[%0d] got=%h/%b exp=%h/%b", j, got_r[j], got_f[j], er, ef);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      int lat, seen = 0; logic [15:0] r, er; logic [3:0] f, ef; logic [4:0] lo; logic [7:0] lb, hb;
      start = 1'b1; op16 = 2'd0; a16 = 16'h8F7F; b16 = 16'h7181; flag_in = 4'b1111;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
      reset = 1'b1; #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL midrst_ctrl got busy=%b done=%b exp 0 0", busy, done);
      end
      checks++; if (result !== 16'h0000 || flag_out !== 4'h0) begin
         failures++; $display("FAIL midrst_data got=%h/%b exp=0000/0000", result, flag_out);
      end
      @(posedge clk); #1; reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
      ref16(2'd0, 16'h1234, 16'hEDCC, 4'b1001, er, ef);
      do_op(2'd0, 16'h1234, 16'hEDCC, 4'b1001, lat, r, f, lo, lb, hb);
      checks++; if (lat != 3 || r !== er || f !== ef) begin
         failures++; $display("FAIL midrst_recover got lat=%0d %h/%b exp lat=3 %h/%b", lat, r, f, er, ef);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op16 = '0; a16 = '0; b16 = '0; flag_in = '0;
      test_reset();
      test_add16();
      test_inc_dec();
      test_add_sp_e();
      test_random();
      test_back_to_back();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

endmodule
